prga_decrypt: RTL and testbench

RC4 pseudo-random generation and decryption stage. Sits directly downstream of the key-scheduling shuffle stage: once the shuffle has left a permuted S array in the shared 256x8 S RAM, this block continues the i/j swap walk over S. It XORs each generated keystream byte with one ciphertext byte from the message ROM and writes the result into the plaintext RAM. It then raises `done` for the top-level controller.

---
 rtl/prga_decrypt.sv | 156 +++++++++++++++
 tb/tb_prga_decrypt.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt.sv
// RC4 keystream generator and decryptor: walks i/j over the shared S RAM, XORs each keystream byte with the ciphertext.
// Optional PRGA_ASCII_CHECK_EN: abort on the first plaintext byte outside {space, a..z} and flag key_bad.
module prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              key_bad,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    input  logic [7:0]        s_rddata,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC_I,
        ST_RD_I,
        ST_LD_I,
        ST_RD_J,
        ST_LD_J,
        ST_WR_I,
        ST_WR_J,
        ST_RD_F,
        ST_LD_F,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

    state_t            state_reg;
    logic [7:0]        i_reg;
    logic [7:0]        j_reg;
    logic [7:0]        si_reg;
    logic [7:0]        sj_reg;
    logic [ADDR_W-1:0] k_reg;

    // Keystream and ciphertext bytes both arrive in LD_F, so the plaintext path is combinational.
    logic [7:0] pt_byte;
    logic       byte_ok;
    assign pt_byte   = s_rddata ^ ct_rddata;
    assign pt_wrdata = pt_wren ? pt_byte : 8'h00;

`ifdef PRGA_ASCII_CHECK_EN
    logic key_bad_reg;
    assign byte_ok = (pt_byte == 8'h20) || ((pt_byte >= 8'h61) && (pt_byte <= 8'h7a));
    assign key_bad = key_bad_reg;
`else
    assign byte_ok = 1'b1;
    assign key_bad = 1'b0;
`endif

    // Outputs are registered: each state's bus values are loaded on the transition into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            i_reg     <= 8'h00;
            j_reg     <= 8'h00;
            si_reg    <= 8'h00;
            sj_reg    <= 8'h00;
            k_reg     <= '0;
            done      <= 1'b0;
            s_addr    <= 8'h00;
            s_wrdata  <= 8'h00;
            s_wren    <= 1'b0;
            ct_addr   <= '0;
            pt_addr   <= '0;
            pt_wren   <= 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
            key_bad_reg <= 1'b0;
`endif
        end else begin
            s_addr   <= 8'h00;
            s_wrdata <= 8'h00;
            s_wren   <= 1'b0;
            ct_addr  <= '0;
            pt_addr  <= '0;
            pt_wren  <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg <= ST_INC_I;
                        i_reg     <= 8'h00;
                        j_reg     <= 8'h00;
                        k_reg     <= '0;
                        done      <= 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
                        key_bad_reg <= 1'b0;
`endif
                    end
                end
                ST_INC_I: begin
                    i_reg     <= i_reg + 8'd1;
                    s_addr    <= i_reg + 8'd1;
                    state_reg <= ST_RD_I;
                end
                ST_RD_I: state_reg <= ST_LD_I;
                ST_LD_I: begin
                    si_reg    <= s_rddata;
                    j_reg     <= j_reg + s_rddata;
                    s_addr    <= j_reg + s_rddata;
                    state_reg <= ST_RD_J;
                end
                ST_RD_J: state_reg <= ST_LD_J;
                ST_LD_J: begin
                    sj_reg    <= s_rddata;
                    s_addr    <= i_reg;
                    s_wrdata  <= s_rddata;
                    s_wren    <= 1'b1;
                    state_reg <= ST_WR_I;
                end
                ST_WR_I: begin
                    s_addr    <= j_reg;
                    s_wrdata  <= si_reg;
                    s_wren    <= 1'b1;
                    state_reg <= ST_WR_J;
                end
                ST_WR_J: begin
                    s_addr    <= si_reg + sj_reg;
                    ct_addr   <= k_reg;
                    state_reg <= ST_RD_F;
                end
                ST_RD_F: begin
                    pt_addr   <= k_reg;
                    pt_wren   <= 1'b1;
                    state_reg <= ST_LD_F;
                end
                ST_LD_F: begin
                    if (!byte_ok) begin
`ifdef PRGA_ASCII_CHECK_EN
                        key_bad_reg <= 1'b1;
`endif
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (k_reg == K_LAST) begin
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        k_reg     <= k_reg + 1'b1;
                        state_reg <= ST_INC_I;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed bench for prga_decrypt: behavioural S RAM / ciphertext ROM / plaintext RAM plus a reference RC4 model.
module tb_prga_decrypt;
    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              done;
    logic              key_bad;
    logic [7:0]        s_addr;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic [7:0]        s_rddata;
    logic [ADDR_W-1:0] ct_addr;
    logic [7:0]        ct_rddata;
    logic [ADDR_W-1:0] pt_addr;
    logic [7:0]        pt_wrdata;
    logic              pt_wren;

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .key_bad(key_bad),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    wire [37:0] all_outs = {done, key_bad, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren};

    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] ct_mem [32];
    logic [7:0] pt_mem [32];
    logic       s_load;
    logic       pt_clr;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_load) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (pt_clr) begin
            for (int x = 0; x < 32; x++) pt_mem[x] <= 8'h00;
        end else if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
        end
    end

    int         pt_wr_cnt = 0;
    int         sw_cnt = 0;
    int         dual_cnt = 0;
    logic [7:0] sw_addr_log [1024];
    logic [7:0] sw_data_log [1024];

    always @(negedge clk) begin
        if (pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
        if (s_wren) begin
            sw_addr_log[sw_cnt[9:0]] <= s_addr;
            sw_data_log[sw_cnt[9:0]] <= s_wrdata;
            sw_cnt <= sw_cnt + 1;
        end
        if (s_wren && pt_wren) dual_cnt <= dual_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int t0       = 0;
    logic [7:0] m_s [256];
    logic [7:0] m_ks [32];

    task tick();
        @(negedge clk);
        #1;
    endtask

    task do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc - 1;
    endtask

    task goto_cycle(input int c);
        while (cyc - t0 < c) tick();
    endtask

    task wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int n = 0; n < budget; n++) begin
            if (done) begin
                dcyc = cyc - t0;
                break;
            end
            tick();
        end
    endtask

    task load_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        s_load = 1'b1;
        tick();
        s_load = 1'b0;
    endtask

    task load_ksa(input logic [23:0] key);
        logic [7:0] kb [3];
        logic [7:0] j;
        logic [7:0] t;
        kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        j = 8'h00;
        for (int x = 0; x < 256; x++) begin
            j = j + s_init[x] + kb[x % 3];
            t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
        end
        s_load = 1'b1;
        tick();
        s_load = 1'b0;
    endtask

    // Textbook RC4 PRGA over a copy of s_init.
    task model_prga(input int n);
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
        i = 8'h00; j = 8'h00;
        for (int k = 0; k < n; k++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            t = m_s[i] + m_s[j];
            m_ks[k] = m_s[t];
        end
    endtask

    task clear_pt();
        pt_clr = 1'b1;
        tick();
        pt_clr = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1;
        repeat (2) begin
            start = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++;
        if (all_outs !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (all_outs !== 38'h0) begin
            n_fail++;
            $display("FAIL idle_no_start: got %h want 0", all_outs);
        end
        $display("test_reset done");
    endtask

    task test_identity();
        int dcyc;
        int base_sw;
        int base_pt;
        int bad;
        load_identity();
        for (int k = 0; k < 32; k++) ct_mem[k] = 8'h00;
        clear_pt();
        model_prga(32);
        base_pt = pt_wr_cnt;
        do_start();
        base_sw = sw_cnt;
        wait_done(400, dcyc);
`ifdef PRGA_ASCII_CHECK_EN
        n_checks++;
        if (dcyc !== 10) begin n_fail++; $display("FAIL id_done_cycle: got %0d want 10", dcyc); end
        n_checks++;
        if (key_bad !== 1'b1) begin n_fail++; $display("FAIL id_key_bad: got %b want 1", key_bad); end
        n_checks++;
        if (pt_wr_cnt - base_pt !== 1) begin n_fail++; $display("FAIL id_pt_writes: got %0d want 1", pt_wr_cnt - base_pt); end
        n_checks++;
        if (pt_mem[0] !== 8'h02) begin n_fail++; $display("FAIL id_pt0: got %h want 02", pt_mem[0]); end
`else
        n_checks++;
        if (dcyc !== 289) begin n_fail++; $display("FAIL id_done_cycle: got %0d want 289", dcyc); end
        n_checks++;
        if (pt_mem[0] !== 8'h02) begin n_fail++; $display("FAIL id_pt0: got %h want 02", pt_mem[0]); end
        n_checks++;
        if (pt_mem[1] !== 8'h05) begin n_fail++; $display("FAIL id_pt1: got %h want 05", pt_mem[1]); end
        n_checks++;
        if ({sw_addr_log[base_sw + 2], sw_data_log[base_sw + 2]} !== 16'h0203)
            begin n_fail++; $display("FAIL id_swap_s2: got %h want 0203", {sw_addr_log[base_sw + 2], sw_data_log[base_sw + 2]}); end
        n_checks++;
        if ({sw_addr_log[base_sw + 3], sw_data_log[base_sw + 3]} !== 16'h0302)
            begin n_fail++; $display("FAIL id_swap_s3: got %h want 0302", {sw_addr_log[base_sw + 3], sw_data_log[base_sw + 3]}); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (pt_mem[k] !== m_ks[k]) begin n_fail++; $display("FAIL id_pt[%0d]: got %h want %h", k, pt_mem[k], m_ks[k]); end
        end
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL id_final_s: got %0d differing entries want 0", bad); end
        n_checks++;
        if (key_bad !== 1'b0) begin n_fail++; $display("FAIL id_key_bad: got %b want 0", key_bad); end
        n_checks++;
        if (pt_wr_cnt - base_pt !== 32) begin n_fail++; $display("FAIL id_pt_writes: got %0d want 32", pt_wr_cnt - base_pt); end
`endif
        $display("test_identity done at cycle %0d", dcyc);
    endtask

    task test_plaintext();
        logic [7:0] ct [9];
        logic [7:0] pt [9];
        int dcyc;
        int base_pt;
        ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        load_ksa(24'h4B6579);
        for (int k = 0; k < 32; k++) ct_mem[k] = (k < 9) ? ct[k] : 8'h00;
        clear_pt();
        base_pt = pt_wr_cnt;
        do_start();
        wait_done(400, dcyc);
`ifdef PRGA_ASCII_CHECK_EN
        n_checks++;
        if (dcyc !== 10) begin n_fail++; $display("FAIL pt_done_cycle: got %0d want 10", dcyc); end
        n_checks++;
        if (pt_mem[0] !== 8'h50) begin n_fail++; $display("FAIL pt_byte0: got %h want 50", pt_mem[0]); end
        n_checks++;
        if (key_bad !== 1'b1) begin n_fail++; $display("FAIL pt_key_bad: got %b want 1", key_bad); end
        repeat (20) tick();
        n_checks++;
        if (pt_wr_cnt - base_pt !== 1) begin n_fail++; $display("FAIL pt_writes_after_abort: got %0d want 1", pt_wr_cnt - base_pt); end
        n_checks++;
        if ({done, key_bad} !== 2'b11) begin n_fail++; $display("FAIL pt_hold: got %b want 11", {done, key_bad}); end
`else
        n_checks++;
        if (dcyc !== 289) begin n_fail++; $display("FAIL pt_done_cycle: got %0d want 289", dcyc); end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (pt_mem[k] !== pt[k]) begin n_fail++; $display("FAIL pt_byte[%0d]: got %h want %h", k, pt_mem[k], pt[k]); end
        end
        n_checks++;
        if (key_bad !== 1'b0) begin n_fail++; $display("FAIL pt_key_bad: got %b want 0", key_bad); end
`endif
        $display("test_plaintext done at cycle %0d", dcyc);
    endtask

    // Ciphertext chosen so every plaintext byte is 'a': valid with or without the ASCII check.
    task prep_ascii_run();
        load_identity();
        model_prga(32);
        for (int k = 0; k < 32; k++) ct_mem[k] = m_ks[k] ^ 8'h61;
        clear_pt();
    endtask

    task test_ignore_start();
        int dcyc;
        int bad;
        prep_ascii_run();
        do_start();
        goto_cycle(20);
        start = 1'b1; tick(); start = 1'b0;
        goto_cycle(100);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(400, dcyc);
        n_checks++;
        if (dcyc !== 289) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want 289", dcyc); end
        bad = 0;
        for (int k = 0; k < 32; k++) if (pt_mem[k] !== 8'h61) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL ign_plaintext: got %0d bad bytes want 0", bad); end
        $display("test_ignore_start done at cycle %0d", dcyc);
    endtask

    task test_restart_in_done();
        do_start();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rs_done_drop: got %b want 0", done); end
        goto_cycle(2);
        n_checks++;
        if (s_addr !== 8'h01) begin n_fail++; $display("FAIL rs_i_restart: got %h want 01", s_addr); end
        goto_cycle(4);
        n_checks++;
        if (s_addr !== m_s[1]) begin n_fail++; $display("FAIL rs_j_restart: got %h want %h", s_addr, m_s[1]); end
        goto_cycle(9);
        n_checks++;
        if ({pt_wren, pt_addr} !== 6'b100000) begin n_fail++; $display("FAIL rs_k_restart: got %b want 100000", {pt_wren, pt_addr}); end
        rst = 1'b1; tick(); rst = 1'b0;
        $display("test_restart_in_done done");
    endtask

    task test_reset_midrun();
        int dcyc;
        int base_pt;
        int act;
        int bad;
        prep_ascii_run();
        base_pt = pt_wr_cnt;
        do_start();
        goto_cycle(50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (all_outs !== 38'h0) begin n_fail++; $display("FAIL mr_outs_c51: got %h want 0", all_outs); end
        act = 0;
        repeat (20) begin
            if (all_outs !== 38'h0) act++;
            tick();
        end
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL mr_quiet: got %0d active cycles want 0", act); end
        n_checks++;
        if (pt_wr_cnt - base_pt !== 5) begin n_fail++; $display("FAIL mr_pt_writes: got %0d want 5", pt_wr_cnt - base_pt); end
        prep_ascii_run();
        do_start();
        wait_done(400, dcyc);
        n_checks++;
        if (dcyc !== 289) begin n_fail++; $display("FAIL mr_rerun_done: got %0d want 289", dcyc); end
        bad = 0;
        for (int k = 0; k < 32; k++) if (pt_mem[k] !== 8'h61) bad++;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL mr_rerun_plaintext: got %0d bad bytes want 0", bad); end
        $display("test_reset_midrun done at cycle %0d", dcyc);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        s_load = 1'b0;
        pt_clr = 1'b0;
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int k = 0; k < 32; k++) ct_mem[k] = 8'h00;
        test_reset();
        test_identity();
        test_plaintext();
        test_ignore_start();
        test_restart_in_done();
        test_reset_midrun();
        n_checks++;
        if (dual_cnt !== 0) begin n_fail++; $display("FAIL single_write_per_cycle: got %0d overlaps want 0", dual_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
